// File: rtl/mandel_pixel_writer.sv
// Mandelbrot pixel writer: maps iteration counts to 4-bit gray, buffers them in a FIFO and
// streams one frame of nibbles to the framebuffer write port.
// Optional build macro ITER_LOG_MAP_EN selects a logarithmic gray mapping.
module mandel_pixel_writer #(
    parameter int unsigned ITER_W       = 8,
    parameter int unsigned MAX_ITER     = 255,
    parameter int unsigned FRAME_PIXELS = 76800,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic [ITER_W-1:0] iter_in,
    input  logic              iter_valid,
    output logic              iter_ready,
    output logic [3:0]        write_data_in,
    output logic              write_data,
    output logic              reset_write_ptr,
    input  logic              wrote_data,
    output logic              frame_done,
    output logic              busy
);
    localparam int unsigned CntW = $clog2(FRAME_PIXELS + 1);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW-1:0] FrameCnt = CntW'(FRAME_PIXELS);
    localparam logic [LvlW-1:0] FullLvl  = LvlW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StPtrRst, StStream, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] accept_cnt_q, ack_cnt_q;
    logic [3:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0] level_q;
    logic [3:0]      data_q;
    logic            wr_q;
    logic            fifo_full, fifo_empty, push, pop, ack;

    // Counts at or above MAX_ITER are inside the set and render black.
    function automatic logic [3:0] map_gray(input logic [ITER_W-1:0] it);
        logic [3:0] g;
        g = 4'd0;
        if (it < ITER_W'(MAX_ITER)) begin
`ifdef ITER_LOG_MAP_EN
            // Highest set bit wins: floor(log2(it)) + 1, clamped to 15.
            for (int i = 0; i < int'(ITER_W); i++) begin
                if (it[i]) g = (i >= 14) ? 4'd15 : 4'(i + 1);
            end
`else
            g = (it > ITER_W'(15)) ? 4'd15 : it[3:0];
`endif
        end
        return g;
    endfunction

    assign fifo_full       = (level_q == FullLvl);
    assign fifo_empty      = (level_q == '0);
    assign iter_ready      = (state_q == StStream) && !fifo_full && (accept_cnt_q < FrameCnt);
    assign push            = iter_valid && iter_ready;
    // Pop only when no write is outstanding, which also enforces one idle cycle after an ack.
    assign pop             = (state_q == StStream) && !wr_q && !fifo_empty;
    assign ack             = wr_q && wrote_data;
    assign write_data_in   = data_q;
    assign write_data      = wr_q;
    assign reset_write_ptr = (state_q == StPtrRst);
    assign frame_done      = (state_q == StDone);
    assign busy            = (state_q != StIdle);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Frame sequencing: pointer reset, stream until all acks seen, done pulse.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (frame_start) state_d = StPtrRst;
            StPtrRst: state_d = StStream;
            StStream: if (ack_cnt_q == FrameCnt) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FIFO pointers, fill level and per-frame counters; all cleared at frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            accept_cnt_q <= '0;
            ack_cnt_q    <= '0;
        end else if (state_q == StPtrRst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            accept_cnt_q <= '0;
            ack_cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q     <= wr_ptr_q + 1'b1;
                accept_cnt_q <= accept_cnt_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      level_q <= level_q + 1'b1;
            else if (pop && !push) level_q <= level_q - 1'b1;
            if (ack) ack_cnt_q <= ack_cnt_q + 1'b1;
        end
    end

    // FIFO storage; contents are don't-care once the level is cleared.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= map_gray(iter_in);
    end

    // Write port: load head on pop, hold request until acknowledged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= 4'd0;
            wr_q   <= 1'b0;
        end else if (pop) begin
            data_q <= mem_q[rd_ptr_q];
            wr_q   <= 1'b1;
        end else if (ack) begin
            wr_q   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mandel_pixel_writer.sv
// Directed testbench for mandel_pixel_writer (FRAME_PIXELS=4, FIFO_DEPTH=4); a second
// instance with a larger frame exercises the FIFO-full condition.
module tb_mandel_pixel_writer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       frame_start = 1'b0, iter_valid = 1'b0, wrote_data = 1'b0;
    logic [7:0] iter_in = 8'd0;
    logic       iter_ready, write_data, reset_write_ptr, frame_done, busy;
    logic [3:0] write_data_in;

    logic       frame_start2 = 1'b0, iter_valid2 = 1'b0, wrote_data2 = 1'b0;
    logic [7:0] iter_in2 = 8'd0;
    logic       iter_ready2, write_data2, reset_write_ptr2, frame_done2, busy2;
    logic [3:0] write_data_in2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mandel_pixel_writer #(.ITER_W(8), .MAX_ITER(255), .FRAME_PIXELS(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .iter_in(iter_in),
        .iter_valid(iter_valid), .iter_ready(iter_ready), .write_data_in(write_data_in),
        .write_data(write_data), .reset_write_ptr(reset_write_ptr), .wrote_data(wrote_data),
        .frame_done(frame_done), .busy(busy)
    );

    mandel_pixel_writer #(.ITER_W(8), .MAX_ITER(255), .FRAME_PIXELS(16), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start2), .iter_in(iter_in2),
        .iter_valid(iter_valid2), .iter_ready(iter_ready2), .write_data_in(write_data_in2),
        .write_data(write_data2), .reset_write_ptr(reset_write_ptr2), .wrote_data(wrote_data2),
        .frame_done(frame_done2), .busy(busy2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({iter_ready, write_data, write_data_in, reset_write_ptr, frame_done, busy} !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0", {iter_ready, write_data, write_data_in,
                     reset_write_ptr, frame_done, busy});
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_frame_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        checks++;
        if (reset_write_ptr !== 1'b1) begin
            errors++; $display("FAIL fs_ptr_pulse got %b want 1", reset_write_ptr);
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL fs_busy got %b want 1", busy); end
        checks++;
        if (iter_ready !== 1'b0) begin errors++; $display("FAIL fs_ready_early got %b want 0", iter_ready); end
        tick();
        checks++;
        if (reset_write_ptr !== 1'b0) begin
            errors++; $display("FAIL fs_ptr_single got %b want 0", reset_write_ptr);
        end
        checks++;
        if (iter_ready !== 1'b1) begin errors++; $display("FAIL fs_ready got %b want 1", iter_ready); end
    endtask

    // Continues the frame opened by test_frame_start.
    task automatic test_stream();
        logic [7:0] vals [4];
        logic [3:0] expv [4];
        int push_i = 0, ack_i = 0, push_c = -1, wd_c = -1;
        bit done = 0;
        vals = '{8'd3, 8'd20, 8'd255, 8'd0};
`ifdef ITER_LOG_MAP_EN
        expv = '{4'd2, 4'd5, 4'd0, 4'd0};
`else
        expv = '{4'd3, 4'd15, 4'd0, 4'd0};
`endif
        for (int c = 0; c < 40 && !done; c++) begin
            if (frame_done) done = 1;
            iter_valid = 1'b0;
            wrote_data = 1'b0;
            if (!done) begin
                if (iter_ready && push_i < 4) begin
                    if (push_c < 0) push_c = c;
                    iter_valid = 1'b1;
                    iter_in = vals[push_i];
                    push_i++;
                end
                if (write_data) begin
                    if (wd_c < 0) wd_c = c;
                    checks++;
                    if (ack_i > 3 || write_data_in !== expv[ack_i]) begin
                        errors++;
                        $display("FAIL stream_pix%0d got %0d want %0d", ack_i, write_data_in,
                                 (ack_i > 3) ? 0 : expv[ack_i]);
                    end
                    ack_i++;
                    wrote_data = 1'b1;
                end
            end
            tick();
        end
        iter_valid = 1'b0;
        wrote_data = 1'b0;
        checks++;
        if (!done || ack_i != 4) begin
            errors++; $display("FAIL stream_done got acks=%0d done=%0d want 4 1", ack_i, done);
        end
        checks++;
        if (wd_c - push_c != 2) begin
            errors++; $display("FAIL stream_latency got %0d want 2", wd_c - push_c);
        end
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL stream_idle got fd=%b busy=%b want 0 0", frame_done, busy);
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        bit changed = 0, got_ready = 0, ptr_seen = 0, done = 0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        for (int c = 0; c < 10; c++) begin
            iter_valid = 1'b1;
            iter_in = (acc % 2 == 1) ? 8'd2 : 8'd1;
            if (iter_ready) acc++;
            if (write_data && write_data_in !== 4'd1) changed = 1;
            tick();
        end
        checks++;
        if (acc != 4) begin errors++; $display("FAIL bp_accepted got %0d want 4", acc); end
        checks++;
        if (iter_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b want 0", iter_ready); end
        checks++;
        if (write_data !== 1'b1 || changed) begin
            errors++; $display("FAIL bp_hold got wd=%b changed=%0d want 1 0", write_data, changed);
        end
        // Drain with iter_valid still high; a stray frame_start must be ignored.
        for (int c = 0; c < 30 && !done; c++) begin
            if (frame_done) done = 1;
            if (iter_ready) got_ready = 1;
            if (reset_write_ptr) ptr_seen = 1;
            frame_start = (c == 3);
            wrote_data = write_data;
            tick();
        end
        frame_start = 1'b0;
        wrote_data = 1'b0;
        checks++;
        if (got_ready || ptr_seen || !done) begin
            errors++;
            $display("FAIL bp_drain got ready=%0d ptr=%0d done=%0d want 0 0 1", got_ready, ptr_seen, done);
        end
        checks++;
        if (iter_ready !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_idle got ready=%b busy=%b want 0 0", iter_ready, busy);
        end
        iter_valid = 1'b0;
    endtask

    task automatic test_log_map();
        logic [7:0] vals [4];
        logic [3:0] expv [4];
        int k = 0, acc = 0;
        bit done = 0;
        vals = '{8'd1, 8'd2, 8'd7, 8'd200};
`ifdef ITER_LOG_MAP_EN
        expv = '{4'd1, 4'd2, 4'd3, 4'd8};
`else
        expv = '{4'd1, 4'd2, 4'd7, 4'd15};
`endif
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        for (int c = 0; c < 10; c++) begin
            iter_valid = 1'b0;
            if (iter_ready && acc < 4) begin
                iter_valid = 1'b1;
                iter_in = vals[acc];
                acc++;
            end
            tick();
        end
        iter_valid = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (frame_done) done = 1;
            wrote_data = 1'b0;
            if (write_data && !done) begin
                checks++;
                if (k > 3 || write_data_in !== expv[k]) begin
                    errors++;
                    $display("FAIL map_pix%0d got %0d want %0d", k, write_data_in, (k > 3) ? 0 : expv[k]);
                end
                k++;
                wrote_data = 1'b1;
            end
            tick();
        end
        wrote_data = 1'b0;
        checks++;
        if (k != 4 || !done) begin
            errors++; $display("FAIL map_done got acks=%0d done=%0d want 4 1", k, done);
        end
    endtask

    task automatic test_fifo_full();
        int acc = 0;
        frame_start2 = 1'b1;
        tick();
        frame_start2 = 1'b0;
        tick();
        for (int c = 0; c < 10; c++) begin
            iter_valid2 = 1'b1;
            iter_in2 = 8'd2;
            if (iter_ready2) acc++;
            tick();
        end
        iter_valid2 = 1'b0;
        checks++;
        if (acc != 5) begin errors++; $display("FAIL full_accepted got %0d want 5", acc); end
        checks++;
        if (iter_ready2 !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", iter_ready2); end
        checks++;
        if (write_data2 !== 1'b1 || write_data_in2 !== 4'd2) begin
            errors++; $display("FAIL full_out got wd=%b data=%0d want 1 2", write_data2, write_data_in2);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit wd_seen = 0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        iter_valid = 1'b1;
        iter_in = 8'd9;
        tick();
        iter_valid = 1'b0;
        tick();
        checks++;
        if (write_data !== 1'b1) begin errors++; $display("FAIL mid_pre_wd got %b want 1", write_data); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({iter_ready, write_data, write_data_in, reset_write_ptr, frame_done, busy} !== 9'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs got %b want 0", {iter_ready, write_data, write_data_in,
                     reset_write_ptr, frame_done, busy});
        end
        tick();
        rst_n = 1'b1;
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        checks++;
        if (reset_write_ptr !== 1'b1) begin
            errors++; $display("FAIL mid_restart_ptr got %b want 1", reset_write_ptr);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            if (write_data) wd_seen = 1;
        end
        checks++;
        if (wd_seen || iter_ready !== 1'b1) begin
            errors++; $display("FAIL mid_flushed got wd=%0d ready=%b want 0 1", wd_seen, iter_ready);
        end
    endtask

    initial begin
        test_reset();
        test_frame_start();
        test_stream();
        test_backpressure();
        test_log_map();
        test_fifo_full();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
